maze_path_player: RTL and testbench
===================================

# maze_path_player

Replays a solved maze path from the solver's direction stack as a stream of single moves. The stack is read bottom-up, i.e. in forward path order, through a synchronous-read port. Each move is offered on a valid/ready handshake to a downstream consumer (motor/display driver), and the block tracks the resulting grid location. It sits after the maze solver. The solver pushes one 2-bit direction per forward step; this block is the reader of that stack after the solver asserts done.

## Interface
Parameters:
- none; 16x16 grid, 8-bit locations and 2-bit directions are fixed.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  start replay; sampled only in IDLE, DONE or ERR.
- stkCount  in  8  number of valid stack entries; sampled when run is accepted.
- stkRdEn  out  1  stack read strobe.
- stkRdAddr  out  8  stack read address; entry 0 is the oldest (first step).
- stkRdData  in  2  direction read from the stack; valid the cycle after stkRdEn.
- move  out  2  direction offered to the consumer.
- moveValid  out  1  move is valid.
- moveReady  in  1  consumer accepts the move.
- curLoc  out  8  current location {row[7:4], col[3:0]}.
- busy  out  1  replay in progress.
- done  out  1  path replayed and ended at destination 8'hFF.
- err  out  1  path left the grid or ended off-destination.

## Operation
- Direction encoding:
  - 00: col+1
  - 01: row+1
  - 10: col-1
  - 11: row-1
- Start location is 8'h00; destination is 8'hFF.
- States: IDLE, FETCH, WAIT, OFFER, FINISH, DONE, ERR.
- IDLE/DONE/ERR, run=1: latch stkCount into cnt; clear idx and curLoc; clear done and err.
  - Next state is FETCH if cnt!=0.
  - Next state is FINISH if cnt==0.
- FETCH: stkRdEn=1, stkRdAddr=idx. Next state is WAIT.
- WAIT: capture stkRdData into dirReg. Next state is OFFER.
- OFFER: moveValid=1, move=dirReg. Holds until moveReady=1. On the accepting edge:
  - If the move would cross a grid edge (col 15 with dir 00, row 15 with 01, col 0 with 10, row 0 with 11), go to ERR. curLoc is unchanged.
  - Otherwise update curLoc with 4-bit field arithmetic and increment idx.
  - Then go to FINISH if idx+1==cnt, else FETCH.
- FINISH: go to DONE if curLoc==8'hFF, else ERR.
- DONE: done=1. ERR: err=1. Both hold, with curLoc frozen, until the next run.
- busy=1 in FETCH, WAIT, OFFER and FINISH.
- run is ignored while busy.
- stkRdAddr holds its last value outside FETCH.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: stkRdEn, stkRdAddr=8'h00, move=2'b00, moveValid, curLoc=8'h00, busy, done, err.
  - Internal registers idx=0, cnt=0, dirReg=0.
- Async rst mid-replay returns to IDLE immediately and drops moveValid. No further stack reads are issued.
- Latency from run sampled to the first moveValid is 3 edges: FETCH, WAIT, OFFER.
- With moveReady held at 1, one move is emitted every 3 cycles.
- moveValid, once high, stays high with move stable until accepted. It never deasserts without acceptance except on rst.
- curLoc changes on the same edge that completes the handshake.
- The last accepted move is followed by FINISH one cycle later, with done or err asserted the cycle after that.
- The stack must not change while busy; the upstream solver guarantees this.

## Test plan
- Reset mid-OFFER → all outputs return to their reset values immediately; the next run restarts from curLoc 8'h00 and idx 0.
- stkCount=30: 15×dir 00 then 15×dir 01, moveReady tied to 1.
  - Required: 30 moves in order, each moveValid pulse 1 cycle, 3-cycle spacing.
  - Required: final curLoc 8'hFF; done=1 at cycle 3·30+2 after run.
- Same path, moveReady low for 5 cycles on move 7.
  - Required: move and moveValid stable throughout the stall.
  - Required: curLoc unchanged until the accept; total time extended by 5 cycles.
- stkCount=1, dir 11 from 8'h00 → ERR after the accept; err=1, curLoc stays 8'h00, no further stkRdEn.
- stkCount=0, run → FINISH then ERR; err=1 two cycles after run, no stack reads. A subsequent run with a valid path clears err and completes with done.
- Run pulsed again while in OFFER → ignored; idx and cnt unchanged, replay completes normally.

Source files
------------

// File: rtl/maze_path_player.sv
// Replays a solved maze path from the solver's direction stack, one move per
// valid/ready handshake, while tracking the resulting grid location.
module maze_path_player (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] stkCount,
    output logic       stkRdEn,
    output logic [7:0] stkRdAddr,
    input  logic [1:0] stkRdData,
    output logic [1:0] move,
    output logic       moveValid,
    input  logic       moveReady,
    output logic [7:0] curLoc,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_OFFER  = 3'd3,
        S_FINISH = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] idx;
    logic [7:0] idx_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] loc_nxt;
    logic [1:0] dir_reg;
    logic [1:0] dir_nxt;
    logic [3:0] row;
    logic [3:0] col;
    logic       edge_hit;
    logic [7:0] stepped_loc;
    logic       last_move;

    assign row  = curLoc[7:4];
    assign col  = curLoc[3:0];
    assign move = dir_reg;

    // Widened compare so a full 255-entry path cannot wrap the index test.
    assign last_move = (({1'b0, idx} + 9'd1) == {1'b0, cnt});

    // Legality of the offered direction and the location it leads to.
    always_comb begin
        edge_hit    = 1'b0;
        stepped_loc = curLoc;
        case (dir_reg)
            2'b00: begin
                edge_hit    = (col == 4'd15);
                stepped_loc = {row, col + 4'd1};
            end
            2'b01: begin
                edge_hit    = (row == 4'd15);
                stepped_loc = {row + 4'd1, col};
            end
            2'b10: begin
                edge_hit    = (col == 4'd0);
                stepped_loc = {row, col - 4'd1};
            end
            default: begin
                edge_hit    = (row == 4'd0);
                stepped_loc = {row - 4'd1, col};
            end
        endcase
    end

    // Next-state and next-datapath decode.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        loc_nxt   = curLoc;
        dir_nxt   = dir_reg;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (run) begin
                    cnt_nxt   = stkCount;
                    idx_nxt   = 8'd0;
                    loc_nxt   = 8'h00;
                    state_nxt = (stkCount == 8'd0) ? S_FINISH : S_FETCH;
                end else begin
                    state_nxt = state;
                end
            end
            S_FETCH: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                dir_nxt   = stkRdData;
                state_nxt = S_OFFER;
            end
            S_OFFER: begin
                if (moveReady) begin
                    if (edge_hit) begin
                        state_nxt = S_ERR;
                    end else begin
                        loc_nxt   = stepped_loc;
                        idx_nxt   = idx + 8'd1;
                        state_nxt = last_move ? S_FINISH : S_FETCH;
                    end
                end else begin
                    state_nxt = S_OFFER;
                end
            end
            S_FINISH: begin
                state_nxt = (curLoc == 8'hFF) ? S_DONE : S_ERR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and outputs, registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 8'd0;
            cnt       <= 8'd0;
            dir_reg   <= 2'b00;
            curLoc    <= 8'h00;
            stkRdEn   <= 1'b0;
            stkRdAddr <= 8'h00;
            moveValid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            dir_reg   <= dir_nxt;
            curLoc    <= loc_nxt;
            stkRdEn   <= (state_nxt == S_FETCH);
            if (state_nxt == S_FETCH) begin
                stkRdAddr <= idx_nxt;
            end
            moveValid <= (state_nxt == S_OFFER);
            busy      <= (state_nxt == S_FETCH) || (state_nxt == S_WAIT) ||
                         (state_nxt == S_OFFER) || (state_nxt == S_FINISH);
            done      <= (state_nxt == S_DONE);
            err       <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_maze_path_player.sv
// Randomized self-checking bench for maze_path_player against a grid-walk model.
module tb_maze_path_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] stkCount;
    logic       stkRdEn;
    logic [7:0] stkRdAddr;
    logic [1:0] stkRdData = 2'b00;
    logic [1:0] move;
    logic       moveValid;
    logic       moveReady;
    logic [7:0] curLoc;
    logic       busy;
    logic       done;
    logic       err;

    logic [1:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    maze_path_player dut (
        .clk(clk), .rst(rst), .run(run), .stkCount(stkCount),
        .stkRdEn(stkRdEn), .stkRdAddr(stkRdAddr), .stkRdData(stkRdData),
        .move(move), .moveValid(moveValid), .moveReady(moveReady),
        .curLoc(curLoc), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read direction stack.
    always @(posedge clk) begin
        if (stkRdEn) stkRdData <= mem[stkRdAddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rden"}, stkRdEn, 0);
        chk({tag, "_addr"}, stkRdAddr, 0);
        chk({tag, "_move"}, move, 0);
        chk({tag, "_valid"}, moveValid, 0);
        chk({tag, "_loc"}, curLoc, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic load_fixed();
        for (int i = 0; i < 30; i++) mem[i] = (i < 15) ? 2'd0 : 2'd1;
    endtask

    task automatic load_random_valid();
        int a = 15;
        int b = 15;
        for (int i = 0; i < 30; i++) begin
            if (a > 0 && (b == 0 || $urandom_range(0, 1) == 0)) begin
                mem[i] = 2'd0; a--;
            end else begin
                mem[i] = 2'd1; b--;
            end
        end
    endtask

    task automatic load_random_any(input int n);
        for (int i = 0; i < n; i++) mem[i] = 2'($urandom_range(0, 3));
    endtask

    // Replays mem[0..n-1]; stall_mv/run_at/rst_at name a 1-based move (0 = unused).
    task automatic replay(input int n, input bit rnd_ready, input int stall_mv,
                          input int stall_len, input int run_at, input int rst_at);
        int r, c, bad, exp_end, k, cyc, extra, reads, stall_left, pr, pc, nr, nc;
        bit exp_done, pending, accepted, fin;
        logic [7:0] end_loc;
        r = 0; c = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            nr = r; nc = c;
            case (mem[i])
                2'd0: nc = c + 1;
                2'd1: nr = r + 1;
                2'd2: nc = c - 1;
                default: nr = r - 1;
            endcase
            if (nr < 0 || nr > 15 || nc < 0 || nc > 15) begin
                bad = i + 1;
                break;
            end
            r = nr; c = nc;
        end
        exp_done = (bad == 0) && (r == 15) && (c == 15);
        exp_end  = (n == 0) ? 2 : (bad != 0) ? 3 * bad + 1 : 3 * n + 2;

        @(negedge clk);
        stkCount = n[7:0]; run = 1'b1; moveReady = 1'b1;
        @(negedge clk);
        run = 1'b0;
        cyc = 1; pr = 0; pc = 0; k = 0; extra = 0; reads = 0;
        pending = 0; accepted = 0; stall_left = 0; fin = 0;
        while (!fin) begin
            if (cyc > 4000) begin
                chk("timeout", 32'd1, 32'd0);
                fin = 1;
            end else if (done || err) begin
                chk("done", done, exp_done);
                chk("err", err, !exp_done);
                chk("end_cycle", cyc, exp_end + extra);
                chk("moves", k, (bad != 0) ? bad : n);
                chk("reads", reads, (bad != 0) ? bad : n);
                chk("final_loc", curLoc, {r[3:0], c[3:0]});
                chk("busy_end", busy, 0);
                fin = 1;
            end else begin
                if (stkRdEn) reads++;
                chk("busy", busy, 1);
                if (accepted) chk("valid_drop", moveValid, 0);
                if (pending) chk("valid_hold", moveValid, 1);
                accepted = 0;
                if (moveValid) begin
                    if (!pending) chk("offer_cycle", cyc, 3 * (k + 1) + extra);
                    chk("move", move, mem[k]);
                    chk("loc", curLoc, {pr[3:0], pc[3:0]});
                    if (rst_at == k + 1) begin
                        rst = 1'b1;
                        #1;
                        chk_reset_outputs("rst_mid");
                        @(negedge clk);
                        rst = 1'b0;
                        return;
                    end
                    if (!pending && stall_mv == k + 1) stall_left = stall_len;
                    if (run_at == k + 1 && !pending) begin
                        run = 1'b1; stkCount = 8'd5;
                    end else begin
                        run = 1'b0;
                    end
                    if (stall_left > 0) begin
                        moveReady = 1'b0; stall_left--;
                    end else begin
                        moveReady = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                    end
                    if (moveReady) begin
                        nr = pr; nc = pc;
                        case (mem[k])
                            2'd0: nc = pc + 1;
                            2'd1: nr = pr + 1;
                            2'd2: nc = pc - 1;
                            default: nr = pr - 1;
                        endcase
                        if (nr >= 0 && nr <= 15 && nc >= 0 && nc <= 15) begin
                            pr = nr; pc = nc;
                        end
                        k++;
                        accepted = 1; pending = 0;
                    end else begin
                        extra++; pending = 1;
                    end
                end else begin
                    run = 1'b0; pending = 0;
                    moveReady = rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
                end
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        // The end state must hold with no stack activity until the next run.
        end_loc = curLoc;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk("hold_rden", stkRdEn, 0);
            chk("hold_valid", moveValid, 0);
            chk("hold_loc", curLoc, end_loc);
            chk("hold_done", done, exp_done);
            chk("hold_err", err, !exp_done);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; moveReady = 1'b0; stkCount = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 2'd0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        load_fixed();
        replay(30, 1'b0, 0, 0, 0, 3);
        replay(30, 1'b0, 0, 0, 0, 0);
        replay(30, 1'b0, 7, 5, 0, 0);

        mem[0] = 2'd3;
        replay(1, 1'b0, 0, 0, 0, 0);
        replay(0, 1'b0, 0, 0, 0, 0);
        load_fixed();
        replay(30, 1'b0, 0, 0, 0, 0);
        replay(30, 1'b0, 0, 0, 4, 0);

        for (int t = 0; t < 5; t++) begin
            load_random_valid();
            replay(30, 1'b1, 0, 0, 0, 0);
        end
        for (int t = 0; t < 6; t++) begin
            load_random_any(40);
            replay($urandom_range(1, 40), 1'b1, 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
